// File: rtl/out_adapter_pkg.sv
// Shared types and width helpers for the output adapter.
package out_adapter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int DEF_IN_WIDTH  = 64;
   localparam int DEF_OUT_WIDTH = 8;

   // True when a wide word splits into a whole number of beats.
   function automatic bit width_ok(input int in_w, input int out_w);
      return (out_w > 0) && ((in_w % out_w) == 0);
   endfunction

   function automatic int calc_ratio(input int in_w, input int out_w);
      return in_w / out_w;
   endfunction

   // Beat index needs at least one bit even for a 1:1 ratio.
   function automatic int calc_beat_w(input int ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

   localparam int RATIO  = calc_ratio(DEF_IN_WIDTH, DEF_OUT_WIDTH);
   localparam int BEAT_W = calc_beat_w(RATIO);

endpackage

// File: rtl/out_adapter_if.sv
// Upstream word / downstream beat handshake bundle for the output adapter.
interface out_adapter_if
   import out_adapter_pkg::*;
#(
   parameter int IN_WIDTH  = DEF_IN_WIDTH,
   parameter int OUT_WIDTH = DEF_OUT_WIDTH
);
   logic                 start;
   logic                 in_en;
   logic [IN_WIDTH-1:0]  data_in;
   logic                 fifo_wfull;
   logic [OUT_WIDTH-1:0] data_out;
   logic                 out_en;
   logic                 out_rdy;
   logic                 done;

   modport slave (
      input  start, in_en, data_in, out_rdy,
      output fifo_wfull, data_out, out_en, done
   );

   modport master (
      output start, in_en, data_in, out_rdy,
      input  fifo_wfull, data_out, out_en, done
   );
endinterface

// File: rtl/out_adapter_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data.
// Pointers carry one extra bit so full and empty are distinguishable.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Storage array; contents need no reset because pointers gate visibility.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   // Pointer advance, flushed by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end
endmodule

// File: rtl/out_adapter.sv
// Output adapter: buffers wide result words, serializes them LSB slice
// first onto a narrow valid/ready sink, and frames them with a done pulse.
//
//  state | meaning
//  IDLE  | waiting for start; upstream blocked
//  RUN   | accepting words until the frame count is reached
//  DRAIN | frame complete upstream; emptying FIFO and serializer
module out_adapter
   import out_adapter_pkg::*;
#(
   parameter int IN_WIDTH    = DEF_IN_WIDTH,
   parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
   parameter int DEPTH       = 4,
   parameter int FRAME_WORDS = 1024
) (
   input  logic          clk,
   input  logic          rst,
   out_adapter_if.slave  bus
);
   localparam int RATIO_L = calc_ratio(IN_WIDTH, OUT_WIDTH);
   localparam int BW      = calc_beat_w(RATIO_L);
   localparam int CW      = $clog2(FRAME_WORDS + 1);

   generate
      if (!width_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_width
         $error("out_adapter: IN_WIDTH must be a multiple of OUT_WIDTH");
      end
   endgenerate

   state_t              state;
   state_t              state_nxt;
   logic [CW-1:0]       word_cnt;
   logic                wfull;
   logic                wr;
   logic                fifo_empty;
   logic                fifo_full;
   logic [IN_WIDTH-1:0] fifo_head;
   logic [IN_WIDTH-1:0] ser_word;
   logic                ser_valid;
   logic [BW-1:0]       beat_idx;
   logic                xfer;
   logic                last;
   logic                load;
   logic                drain_ok;
   logic                done_nxt;
   logic                cnt_clr;
   logic                done_q;

   assign wfull    = (state != RUN) || fifo_full || (word_cnt == CW'(FRAME_WORDS));
   assign wr       = bus.in_en && !wfull;
   assign xfer     = ser_valid && bus.out_rdy;
   assign last     = xfer && (beat_idx == BW'(RATIO_L - 1));
   // Load when idle, or back-to-back on the final beat so no bubble appears.
   assign load     = !fifo_empty && (!ser_valid || last);
   assign drain_ok = fifo_empty && (!ser_valid || last);

   sync_fifo #(
      .WIDTH (IN_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr),
      .wr_data (bus.data_in),
      .rd_en   (load),
      .rd_data (fifo_head),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state decode; start outside IDLE has no effect.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (word_cnt == CW'(FRAME_WORDS)) state_nxt = DRAIN;
         DRAIN:   if (drain_ok) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: frame-end pulse request and word-count clear.
   always_comb begin
      done_nxt = 1'b0;
      cnt_clr  = 1'b0;
      case (state)
         IDLE:    cnt_clr  = bus.start;
         DRAIN:   done_nxt = drain_ok;
         default: ;
      endcase
   end

   // Word counter and registered done pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_cnt <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= done_nxt;
         if (cnt_clr)  word_cnt <= '0;
         else if (wr)  word_cnt <= word_cnt + 1'b1;
      end
   end

   // Serializer: shifts the held word down one beat per transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ser_word  <= '0;
         ser_valid <= 1'b0;
         beat_idx  <= '0;
      end else if (load) begin
         ser_word  <= fifo_head;
         ser_valid <= 1'b1;
         beat_idx  <= '0;
      end else if (xfer) begin
         ser_word <= ser_word >> OUT_WIDTH;
         beat_idx <= beat_idx + 1'b1;
         if (last) ser_valid <= 1'b0;
      end
   end

   assign bus.fifo_wfull = wfull;
   assign bus.data_out   = ser_word[OUT_WIDTH-1:0];
   assign bus.out_en     = ser_valid;
   assign bus.done       = done_q;
endmodule

// File: tb/tb_out_adapter.sv
// Bench for out_adapter: two instances (long frame, 4-word frame) share
// stimulus; a queue-based reference model predicts every output each cycle.
module tb_out_adapter;
   localparam int IW  = 64;
   localparam int OW  = 8;
   localparam int DEP = 4;
   localparam int RAT = IW / OW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          sel = 1'b0;
   logic          start = 1'b0;
   logic          in_en = 1'b0;
   logic [IW-1:0] data_in = '0;
   logic          out_rdy = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   out_adapter_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus_a ();
   out_adapter_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus_b ();

   assign bus_a.start   = start;
   assign bus_a.in_en   = in_en;
   assign bus_a.data_in = data_in;
   assign bus_a.out_rdy = out_rdy;
   assign bus_b.start   = start;
   assign bus_b.in_en   = in_en;
   assign bus_b.data_in = data_in;
   assign bus_b.out_rdy = out_rdy;

   out_adapter #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DEP), .FRAME_WORDS(1024)) dut_a (
      .clk (clk), .rst (rst), .bus (bus_a.slave));
   out_adapter #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DEP), .FRAME_WORDS(4)) dut_b (
      .clk (clk), .rst (rst), .bus (bus_b.slave));

   logic [OW-1:0] o_data;
   logic          o_en, o_wfull, o_done;
   assign o_data  = sel ? bus_b.data_out   : bus_a.data_out;
   assign o_en    = sel ? bus_b.out_en     : bus_a.out_en;
   assign o_wfull = sel ? bus_b.fifo_wfull : bus_a.fifo_wfull;
   assign o_done  = sel ? bus_b.done       : bus_a.done;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Frame phase: 0 waiting for start, 1 accepting, 2 emptying.
   logic [IW-1:0] m_fifo [$];
   logic [IW-1:0] m_ser;
   int            m_left, m_idx, m_phase, m_wcnt;
   bit            m_done;
   bit            m_xfer, m_wr, m_was_empty, m_fin;
   int            m_fw;
   assign m_fw = sel ? 4 : 1024;

   function automatic bit m_wfull();
      return (m_phase != 1) || (m_fifo.size() == DEP) || (m_wcnt == m_fw);
   endfunction

   function automatic logic [OW-1:0] m_beat();
      logic [IW-1:0] s;
      s = m_ser >> (m_idx * OW);
      return s[OW-1:0];
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_fifo.delete();
         m_left = 0; m_idx = 0; m_phase = 0; m_wcnt = 0; m_done = 0;
      end else begin
         m_xfer      = (m_left > 0) && out_rdy;
         m_wr        = in_en && !m_wfull();
         m_was_empty = (m_fifo.size() == 0);
         m_fin       = (m_phase == 2) && m_was_empty && (m_left == 0 || (m_xfer && m_left == 1));
         m_done      = m_fin;
         if (m_fin)                                m_phase = 0;
         else if (m_phase == 1 && m_wcnt == m_fw)  m_phase = 2;
         else if (m_phase == 0 && start) begin     m_phase = 1; m_wcnt = 0; end
         if (m_xfer) begin m_left--; m_idx++; end
         if (m_left == 0 && !m_was_empty) begin
            m_ser  = m_fifo.pop_front();
            m_left = RAT;
            m_idx  = 0;
         end
         if (m_wr) begin m_fifo.push_back(data_in); m_wcnt++; end
      end
   end

   // Every-cycle comparison of the selected instance against the model.
   always @(negedge clk) begin
      if (rst) begin
         check("out_en", o_en, (m_left > 0));
         if (m_left > 0) check("data_out", o_data, m_beat());
         check("fifo_wfull", o_wfull, m_wfull());
         check("done", o_done, m_done);
      end
   end

   int beats = 0;
   int dones = 0;
   always @(posedge clk) if (rst && o_en && out_rdy) beats++;
   always @(negedge clk) if (rst && o_done) dones++;

   // ---------------- stimulus helpers ----------------
   task automatic do_reset(input logic which);
      @(negedge clk);
      rst = 1'b0; start = 0; in_en = 0; out_rdy = 0; data_in = '0;
      sel = which;
      repeat (2) @(negedge clk);
      check("rst_out_en", o_en, 1'b0);
      check("rst_data_out", o_data, '0);
      check("rst_done", o_done, 1'b0);
      check("rst_wfull", o_wfull, 1'b1);
      rst = 1'b1;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1; in_en = 0;
      @(negedge clk); start = 0;
   endtask

   task automatic put_word(input logic [IW-1:0] w);
      in_en = 1; data_in = w;
      @(negedge clk); in_en = 0;
   endtask

   initial begin
      int b0, d0, n;

      // 1: single word, latency and order
      do_reset(1'b0);
      out_rdy = 1;
      pulse_start();
      put_word(64'h0807060504030201);
      check("s1_lat_e", o_en, 1'b0);
      @(negedge clk);
      check("s1_lat_e1", o_en, 1'b1);
      check("s1_first", o_data, 8'h01);
      b0 = beats;
      repeat (12) @(negedge clk);
      check("s1_beats", beats - b0, 8);

      // 2: backpressure pattern 1,0,0,1,0,0...
      do_reset(1'b0);
      pulse_start();
      b0 = beats;
      put_word(64'h0807060504030201);
      for (int i = 0; i < 40; i++) begin
         out_rdy = (i % 3 == 0);
         @(negedge clk);
      end
      check("s2_beats", beats - b0, 8);

      // 3: fill with sink stalled; 5 accepted, then 40 gapless beats
      do_reset(1'b0);
      pulse_start();
      for (int i = 0; i < 7; i++) begin
         in_en = 1; data_in = {8{8'(8'h10 * (i + 1))}} + 64'h0706050403020100;
         @(negedge clk);
      end
      in_en = 0;
      repeat (3) @(negedge clk);
      check("s3_full", o_wfull, 1'b1);
      b0 = beats;
      out_rdy = 1;
      repeat (40) @(negedge clk);
      check("s3_beats40", beats - b0, 40);
      repeat (5) @(negedge clk);
      check("s3_empty", o_en, 1'b0);

      // 4: frame end with FRAME_WORDS=4
      do_reset(1'b1);
      out_rdy = 1;
      pulse_start();
      d0 = dones;
      for (int i = 0; i < 4; i++) put_word({$urandom, $urandom});
      repeat (60) @(negedge clk);
      check("s4_done_cnt", dones - d0, 1);
      check("s4_wfull_idle", o_wfull, 1'b1);

      // 5: asynchronous reset during beat 3 of word 1
      do_reset(1'b0);
      out_rdy = 1;
      pulse_start();
      b0 = beats;
      put_word(64'h1817161514131211);
      put_word(64'h2827262524232221);
      n = 0;
      while (beats - b0 != 2 && n < 50) begin @(negedge clk); n++; end
      check("s5_wait", (beats - b0 == 2), 1'b1);
      check("s5_beat3", o_data, 8'h13);
      #2 rst = 1'b0;
      #1;
      check("s5_out_en", o_en, 1'b0);
      check("s5_done", o_done, 1'b0);
      check("s5_wfull", o_wfull, 1'b1);
      @(negedge clk); rst = 1'b1;
      pulse_start();
      put_word({8{8'hAA}});
      n = 0;
      while (!o_en && n < 20) begin @(negedge clk); n++; end
      check("s5_wait2", o_en, 1'b1);
      check("s5_first_aa", o_data, 8'hAA);
      repeat (10) @(negedge clk);

      // 6: pre-start writes dropped; start in RUN does not clear the count
      do_reset(1'b1);
      out_rdy = 1;
      b0 = beats;
      d0 = dones;
      for (int i = 0; i < 5; i++) begin
         in_en = 1; data_in = {$urandom, $urandom};
         @(negedge clk);
      end
      in_en = 0;
      repeat (3) @(negedge clk);
      check("s6_no_beats", beats - b0, 0);
      pulse_start();
      put_word(64'h1111111111111111);
      put_word(64'h2222222222222222);
      pulse_start();
      put_word(64'h3333333333333333);
      put_word(64'h4444444444444444);
      repeat (60) @(negedge clk);
      check("s6_beats", beats - b0, 32);
      check("s6_done", dones - d0, 1);

      // Random traffic on the long-frame instance
      do_reset(1'b0);
      pulse_start();
      for (int i = 0; i < 600; i++) begin
         in_en   = ($urandom_range(0, 1) == 1);
         data_in = {$urandom, $urandom};
         out_rdy = ($urandom_range(0, 3) != 0);
         start   = ($urandom_range(0, 63) == 0);
         @(negedge clk);
      end

      // Random traffic across several short frames
      do_reset(1'b1);
      d0 = dones;
      for (int i = 0; i < 1500; i++) begin
         in_en   = ($urandom_range(0, 2) != 0);
         data_in = {$urandom, $urandom};
         out_rdy = ($urandom_range(0, 2) != 0);
         start   = ($urandom_range(0, 15) == 0);
         @(negedge clk);
      end
      in_en = 0; start = 0; out_rdy = 1;
      repeat (60) @(negedge clk);
      check("rand_frames", (dones - d0 > 0), 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
